// File: rtl/dmix_clk_pkg.sv
// rtl/dmix_clk_pkg.sv - shared constants, rate encodings and rate-to-shift helper for dmix_clkgen
//
// Purpose:
//   Common definitions for the audio bit-clock generator.
//   - rate_e         : per-channel rate request/state encoding
//   - GCNT_W         : width of the global cycle counter (one 48 kHz frame)
//   - FRAME_BITS     : bits per audio frame (two 32-bit slots)
//   - FRAME_SH       : log2(FRAME_BITS), bit-index width
//   - rate_shift()   : log2(master cycles per bit) for a given rate
package dmix_clk_pkg;

  localparam int GCNT_W     = 11;
  localparam int FRAME_BITS = 64;
  localparam int FRAME_SH   = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    RATE_48K  = 2'd0,
    RATE_96K  = 2'd1,
    RATE_192K = 2'd2,
    RATE_RSVD = 2'd3
  } rate_e;

  // Master cycles per bit are 32/16/8, so the bit boundary is the point where
  // the low 5/4/3 bits of the global counter are all zero.
  function automatic logic [2:0] rate_shift(input logic [1:0] rate);
    logic [2:0] s;
    case (rate)
      RATE_96K:  s = 3'd4;
      RATE_192K: s = 3'd3;
      default:   s = 3'd5;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmix_clkgen_ch.sv
// rtl/dmix_clkgen_ch.sv - one audio channel: rate register and gcnt decode to bit/frame/lr strobes
//
// Purpose:
//   Holds the rate in effect for one channel and decodes the shared global
//   counter into registered bit_en / frame_start / lrck.
//
// Ports:
//   clk          in   master clock
//   rst          in   asynchronous active-high reset
//   locked       in   generator running; outputs forced low when clear
//   load         in   sample rate_sel into rate_cur this cycle
//   rate_sel     in   [1:0] requested rate (RATE_RSVD ignored)
//   gcnt         in   [GCNT_W-1:0] global cycle counter
//   rate_cur     out  [1:0] rate currently in effect
//   bit_en       out  one-cycle pulse at each bit slot start
//   frame_start  out  one-cycle pulse at bit 0
//   lrck         out  0 for bits 0-31, 1 for bits 32-63
module dmix_clkgen_ch
  import dmix_clk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              locked,
  input  logic              load,
  input  logic [1:0]        rate_sel,
  input  logic [GCNT_W-1:0] gcnt,
  output logic [1:0]        rate_cur,
  output logic              bit_en,
  output logic              frame_start,
  output logic              lrck
);

  logic [2:0]        bit_sh;
  logic [3:0]        frame_sh;
  logic [3:0]        lr_idx;
  logic [GCNT_W-1:0] bit_mask;
  logic [GCNT_W-1:0] frame_mask;
  logic              bit_hit;
  logic              frame_hit;
  logic              lr_bit;

  // Reserved requests leave the current rate untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_cur <= RATE_48K;
    end else if (load && (rate_sel != RATE_RSVD)) begin
      rate_cur <= rate_sel;
    end
  end

  // The frame spans FRAME_SH bits above the bit shift; for 48 kHz that is the
  // whole 11-bit counter, where the shifted one falls off and the mask
  // becomes all ones.
  always_comb begin
    bit_sh     = rate_shift(rate_cur);
    frame_sh   = 4'({1'b0, bit_sh}) + 4'(FRAME_SH);
    lr_idx     = frame_sh - 4'd1;
    bit_mask   = (GCNT_W'(1) << bit_sh) - GCNT_W'(1);
    frame_mask = (GCNT_W'(1) << frame_sh) - GCNT_W'(1);
    bit_hit    = (gcnt & bit_mask) == '0;
    frame_hit  = (gcnt & frame_mask) == '0;
    lr_bit     = gcnt[lr_idx];
  end

  // Decode of gcnt value v appears the cycle after gcnt == v.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_en      <= 1'b0;
      frame_start <= 1'b0;
      lrck        <= 1'b0;
    end else begin
      bit_en      <= locked & bit_hit;
      frame_start <= locked & frame_hit;
      lrck        <= locked & lr_bit;
    end
  end

endmodule

// File: rtl/dmix_clkgen.sv
// rtl/dmix_clkgen.sv - multi-channel audio bit/frame clock generator on a 98.304 MHz master clock
//
// Purpose:
//   Runs one 11-bit global counter (one 48 kHz frame = 2048 cycles) and
//   decodes it per channel into bit_en / frame_start / lrck at 48, 96 or
//   192 kHz. Rate changes land only on the common 48 kHz frame boundary or
//   on a sync request.
//
// Configuration:
//   DMIX_CLKGEN_LOCK_EN  when defined, locked rises LOCK_CYCLES cycles after
//                        reset release; otherwise one cycle after release.
//
// Parameters:
//   NUM_CH       number of channels, 1..8
//   LOCK_CYCLES  settling cycles (only with DMIX_CLKGEN_LOCK_EN)
//
// Ports:
//   clk983040    in   98.304 MHz master clock
//   rst          in   asynchronous active-high reset
//   rate_sel     in   [2*NUM_CH-1:0] per-channel rate request
//   sync         in   single-cycle realignment request
//   locked       out  generator running
//   bit_en       out  [NUM_CH-1:0] bit slot start pulses
//   frame_start  out  [NUM_CH-1:0] frame start pulses
//   lrck         out  [NUM_CH-1:0] left/right clock
//   rate_cur     out  [2*NUM_CH-1:0] rate currently in effect
module dmix_clkgen
  import dmix_clk_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                  clk983040,
  input  logic                  rst,
  input  logic [2*NUM_CH-1:0]   rate_sel,
  input  logic                  sync,
  output logic                  locked,
  output logic [NUM_CH-1:0]     bit_en,
  output logic [NUM_CH-1:0]     frame_start,
  output logic [NUM_CH-1:0]     lrck,
  output logic [2*NUM_CH-1:0]   rate_cur
);

  if ((NUM_CH < 1) || (NUM_CH > 8) || (LOCK_CYCLES < 1)) begin : g_bad_param
    $error("dmix_clkgen: parameter out of range");
  end

  logic [GCNT_W-1:0] gcnt;
  logic              lock_rise;
  logic              gcnt_last;
  logic              load;

`ifdef DMIX_CLKGEN_LOCK_EN
  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  logic [LCW-1:0] lock_cnt;

  // locked rises on the LOCK_CYCLES-th edge after release.
  assign lock_rise = !locked && (lock_cnt == LCW'(LOCK_CYCLES - 1));

  always_ff @(posedge clk983040 or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (!locked && !lock_rise) begin
      lock_cnt <= lock_cnt + LCW'(1);
    end
  end
`else
  // No settling time: run from the first edge after release.
  assign lock_rise = !locked;
`endif

  always_ff @(posedge clk983040 or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
    end else if (lock_rise) begin
      locked <= 1'b1;
    end
  end

  assign gcnt_last = (gcnt == '1);

  // Rates are latched when the generator starts, at the last cycle of every
  // 48 kHz frame, and on sync. A sync on the last cycle merges with the
  // natural wrap, so only one frame_start results.
  assign load = lock_rise | (locked & (sync | gcnt_last));

  always_ff @(posedge clk983040 or posedge rst) begin
    if (rst) begin
      gcnt <= '0;
    end else if (!locked || sync) begin
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + GCNT_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    dmix_clkgen_ch u_ch (
      .clk         (clk983040),
      .rst         (rst),
      .locked      (locked),
      .load        (load),
      .rate_sel    (rate_sel[2*k +: 2]),
      .gcnt        (gcnt),
      .rate_cur    (rate_cur[2*k +: 2]),
      .bit_en      (bit_en[k]),
      .frame_start (frame_start[k]),
      .lrck        (lrck[k])
    );
  end

endmodule

// File: tb/tb_dmix_clkgen.sv
// tb/tb_dmix_clkgen.sv - directed self-checking bench for dmix_clkgen (3 channels, rates 0/1/2)
module tb_dmix_clkgen;

  localparam int NCH  = 3;
  localparam int LCYC = 16;
`ifdef DMIX_CLKGEN_LOCK_EN
  localparam int LAT = LCYC;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sync = 1'b0;
  logic [2*NCH-1:0] rate_sel;
  logic           locked;
  logic [NCH-1:0] bit_en;
  logic [NCH-1:0] frame_start;
  logic [NCH-1:0] lrck;
  logic [2*NCH-1:0] rate_cur;

  dmix_clkgen #(.NUM_CH(NCH), .LOCK_CYCLES(LCYC)) dut (
    .clk983040   (clk),
    .rst         (rst),
    .rate_sel    (rate_sel),
    .sync        (sync),
    .locked      (locked),
    .bit_en      (bit_en),
    .frame_start (frame_start),
    .lrck        (lrck),
    .rate_cur    (rate_cur)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;   // expected gcnt after the most recent edge
  int be_cnt[NCH];
  int fs_cnt[NCH];
  int lr_cnt[NCH];
  int coin;
  int lr_bad;
  int fs_first;
  bit first;
  logic [NCH-1:0] lr_prev;
  int n_lock;
  int be_seen;
  int d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos + 1) % 2048;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NCH; k++) begin
      be_cnt[k] = 0;
      fs_cnt[k] = 0;
      lr_cnt[k] = 0;
    end
    coin    = 0;
    lr_bad  = 0;
    first   = 1'b1;
    lr_prev = lrck;
  endtask

  task automatic sample_counts();
    if (first) fs_first = int'(frame_start);
    first = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      be_cnt[k] += int'(bit_en[k]);
      fs_cnt[k] += int'(frame_start[k]);
      lr_cnt[k] += int'(lrck[k]);
      if ((lrck[k] != lr_prev[k]) && !bit_en[k]) lr_bad++;
    end
    if (frame_start == '1) coin++;
    lr_prev = lrck;
  endtask

  task automatic window(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sample_counts();
    end
  endtask

  task automatic advance_to(input int target);
    int g;
    g = 0;
    while ((pos != target) && (g < 4096)) begin
      tick();
      g++;
    end
  endtask

  task automatic wait_lock();
    n_lock  = 0;
    be_seen = 0;
    while (!locked && (n_lock < 5000)) begin
      @(posedge clk);
      #1;
      n_lock++;
      be_seen |= int'(bit_en);
    end
    pos = 0;
  endtask

  initial begin
    rate_sel = {2'd2, 2'd1, 2'd0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_bit_en", bit_en, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_lrck", lrck, 0);
    check("rst_rate_cur", rate_cur, 0);

    rst = 1'b0;
    wait_lock();
    check("lock_latency", n_lock, LAT);
    check("no_bit_en_before_lock", be_seen, 0);
    check("rate_cur_at_lock", rate_cur, 6'b10_01_00);

    // Two full 48 kHz frames from lock.
    clear_counts();
    window(4096);
    check("first_frame_all_ch", fs_first, 7);
    check("be_cnt_ch0", be_cnt[0], 128);
    check("be_cnt_ch1", be_cnt[1], 256);
    check("be_cnt_ch2", be_cnt[2], 512);
    check("fs_cnt_ch0", fs_cnt[0], 2);
    check("fs_cnt_ch1", fs_cnt[1], 4);
    check("fs_cnt_ch2", fs_cnt[2], 8);
    check("lr_high_ch0", lr_cnt[0], 2048);
    check("lr_high_ch1", lr_cnt[1], 2048);
    check("lr_high_ch2", lr_cnt[2], 2048);
    check("fs_coincide", coin, 2);
    check("lrck_off_bit_en", lr_bad, 0);

    // Rate change mid-frame waits for the wrap.
    advance_to(100);
    rate_sel = {2'd2, 2'd1, 2'd2};
    clear_counts();
    window(1947);
    check("pre_wrap_be_ch0", be_cnt[0], 60);
    check("pre_wrap_rate_cur", rate_cur, 6'b10_01_00);
    tick();
    check("post_wrap_rate_cur", rate_cur, 6'b10_01_10);
    clear_counts();
    window(2048);
    check("new_rate_be_ch0", be_cnt[0], 256);
    check("new_rate_fs_ch0", fs_cnt[0], 4);

    // Reserved rate is ignored at the wrap.
    rate_sel = {2'd2, 2'd1, 2'd3};
    clear_counts();
    window(4096);
    check("rsvd_be_ch0", be_cnt[0], 512);
    check("rsvd_rate_cur", rate_cur, 6'b10_01_10);

    // Sync at gcnt 700 realigns and loads rates.
    rate_sel = {2'd2, 2'd1, 2'd0};
    advance_to(700);
    check("pre_sync_rate_cur", rate_cur, 6'b10_01_10);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    pos = 0;
    check("sync_rate_cur", rate_cur, 6'b10_01_00);
    check("sync_no_early_fs", frame_start, 0);
    tick();
    check("sync_fs_all", frame_start, 7);
    d = 0;
    do begin
      tick();
      d++;
    end while (!frame_start[0] && (d < 3000));
    check("sync_next_fs_ch0", d, 2048);

    // Sync on the last cycle gives exactly one frame_start.
    advance_to(2047);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    clear_counts();
    sample_counts();
    window(2047);
    check("sync2047_fs_ch0", fs_cnt[0], 1);
    check("sync2047_fs_ch2", fs_cnt[2], 4);

    // Reset mid-frame clears outputs at once, then relocks cleanly.
    advance_to(505);
    check("pre_rst_bit_en", bit_en, 3'b100);
    check("pre_rst_lrck", lrck, 3'b100);
    rst = 1'b1;
    #1;
    check("mid_rst_bit_en", bit_en, 0);
    check("mid_rst_lrck", lrck, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_rate_cur", rate_cur, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_lock();
    check("relock_latency", n_lock, LAT);
    check("relock_no_bit_en", be_seen, 0);
    tick();
    check("relock_fs_all", frame_start, 7);
    check("relock_rate_cur", rate_cur, 6'b10_01_00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmix_clkgen.md
DMIX_CLKGEN -- requirements
Module: dmix_clkgen

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent audio channels, 1..8.
REQ-002 Parameter LOCK_CYCLES, default 1024: settling cycles after reset before outputs run (used only with DMIX_CLKGEN_LOCK_EN).
REQ-003 Port clk983040  input  1: the 98.304 MHz master clock; the only clock.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port rate_sel  input  2*NUM_CH: per-channel rate request: 0=48 kHz (32 clk/bit), 1=96 kHz (16), 2=192 kHz (8), 3=reserved.
REQ-006 Port sync  input  1: single-cycle realignment request.
REQ-007 Port locked  output  1: high when the generator runs.
REQ-008 Port bit_en  output  NUM_CH: one-cycle pulse at the start of each bit slot.
REQ-009 Port frame_start  output  NUM_CH: one-cycle pulse coincident with bit_en of bit 0.
REQ-010 Port lrck  output  NUM_CH: 0 during bits 0-31, 1 during bits 32-63.
REQ-011 Port rate_cur  output  2*NUM_CH: rate currently in effect per channel.

Function
REQ-012 Frame is 64 bits; frame length SHALL be 2048/1024/512 cycles for rate 0/1/2.
REQ-013 An 11-bit global counter gcnt SHALL increment by 1 every cycle while locked, wrapping 2047->0.
REQ-014 Channel k with shift s (5/4/3 for rate 0/1/2) SHALL assert bit_en[k] when gcnt[s-1:0]==0.
REQ-015 Bit index SHALL be gcnt[s+5:s]; lrck[k] SHALL equal bit index bit 5, registered with bit_en timing (changes the cycle bit_en of bit 32 or bit 0 is high).
REQ-016 frame_start[k] SHALL assert when gcnt[s+5:0]==0.
REQ-017 All outputs SHALL be registered; bit_en/frame_start/lrck SHALL reflect gcnt of the same cycle (zero added latency beyond the output register: decode of gcnt value v appears the cycle after gcnt==v).
REQ-018 rate_sel SHALL be sampled into rate_cur only on the cycle gcnt==2047, taking effect at gcnt==0, so every rate change lands on a common 48 kHz frame boundary.
REQ-019 rate_sel value 3 SHALL be ignored: rate_cur keeps its previous value.
REQ-020 sync high while locked SHALL force gcnt to 0 the next cycle and load rate_sel into rate_cur at that same point; sync during gcnt==2047 behaves identically (no double frame_start).
REQ-021 sync while not locked SHALL be ignored.
REQ-022 While locked==0: bit_en=0, frame_start=0, lrck=0, gcnt held at 0.

Reset
REQ-023 On rst: gcnt=0, rate_cur=0 (48 kHz all channels), bit_en=0, frame_start=0, lrck=0, locked=0, lock counter=0.
REQ-024 rst asserted mid-frame SHALL clear all state immediately; no partial pulse after release.
REQ-025 First frame_start after release SHALL occur on the cycle after locked rises, on all channels simultaneously.

Configuration
REQ-026 Macro DMIX_CLKGEN_LOCK_EN: when defined, locked rises after LOCK_CYCLES cycles following rst release, and rate_sel is loaded into rate_cur at that moment.
REQ-027 Without DMIX_CLKGEN_LOCK_EN: no lock counter; locked=1 on the first cycle after rst release, and rate_cur loads rate_sel on that cycle.

Structure
REQ-028 Shared package dmix_clk_pkg SHALL hold rate encodings (RATE_48K/96K/192K/RSVD), FRAME_BITS=64, GCNT_W=11, and a rate-to-shift function.
REQ-029 Sub-module dmix_clkgen_ch SHALL implement one channel (rate_cur register, decode of gcnt to bit_en/frame_start/lrck), instantiated NUM_CH times; the top holds gcnt, lock logic and sync.

Verification
REQ-030 Reset release, rate_sel all 0, no LOCK_EN -> bit_en every 32 cycles, frame_start every 2048 cycles, lrck high for 1024 cycles per frame.
REQ-031 NUM_CH=3, rates 0/1/2 -> frame_start periods 2048/1024/512, all three coincide every 2048 cycles.
REQ-032 Change rate_sel[0] 0->2 at gcnt=100 -> rate_cur unchanged until gcnt wraps; first 8-cycle bit_en spacing starts at next gcnt==0.
REQ-033 rate_sel=3 at wrap -> rate_cur unchanged, bit_en period unchanged.
REQ-034 sync pulse at gcnt=700 -> frame_start on all channels on the following cycle's decode, then regular periods; sync at gcnt=2047 -> exactly one frame_start.
REQ-035 LOCK_EN, LOCK_CYCLES=16 -> locked rises 16 cycles after rst release, no bit_en before; rst asserted mid-frame -> all outputs 0 within the same cycle.
